sd_spi_responder: RTL and testbench
===================================

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flop stages in each input synchroniser.
REQ-002 Parameter IDLE_BYTE, default 8'hFF, byte shifted out when no transmit byte is queued.
REQ-003 CLK  input  1  system clock; all state on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 SPI_CLK  input  1  serial clock from the initiator; idles high; asynchronous to CLK.
REQ-006 SPI_MOSI  input  1  serial data from the initiator, MSB first.
REQ-007 SPI_CS  input  1  chip select from the initiator, active low.
REQ-008 SPI_MISO  output  1  serial data to the initiator, MSB first.
REQ-009 TxData  input  8  next byte to transmit.
REQ-010 TxLoad  input  1  TxData valid; accepted only when TxReady=1.
REQ-011 TxReady  output  1  transmit holding register empty.
REQ-012 RxData  output  8  last complete received byte.
REQ-013 RxValid  output  1  one-CLK pulse; RxData updated.
REQ-014 TxUnderrun  output  1  one-CLK pulse; byte boundary reached with holding register empty.
REQ-015 Busy  output  1  transfer in progress (SPI_CS low, synchronised).

Function
REQ-016 SPI_CLK, SPI_MOSI and SPI_CS SHALL each pass through SYNC_STAGES flip-flops before use.
REQ-017 Rising and falling SPI_CLK edges SHALL be detected by comparing the synchronised value with its one-cycle-delayed copy.
REQ-018 SPI mode 3 SHALL be used: MOSI sampled on the SPI_CLK rising edge; MISO changes on the falling edge.
REQ-019 Supported SPI_CLK frequency SHALL be at most CLK/8, with each phase at least 4 CLK.
REQ-020 The FSM SHALL have states IDLE, LOAD and SHIFT.
REQ-021 IDLE: SPI_MISO=1, bit counter=0; a synchronised SPI_CS fall moves the FSM to LOAD.
REQ-022 LOAD (one CLK): shift register <= holding register if full (holding becomes empty), else IDLE_BYTE with a TxUnderrun pulse; SPI_MISO <= bit 7; go to SHIFT.
REQ-023 SHIFT, on a rising edge: shift in the synchronised MOSI; bit counter +1 (3-bit, wraps 7->0).
REQ-024 SHIFT, on a falling edge with counter!=0: SPI_MISO <= next shift-register bit.
REQ-025 SHIFT, on a falling edge with counter==0 (after 8 bits): reload as in LOAD and drive the new bit 7, allowing back-to-back bytes without CS deassertion.
REQ-026 After the 8th rising edge, RxData SHALL be written and RxValid pulsed exactly 1 CLK later.
REQ-027 Rx has no back-pressure: an unread RxData is overwritten.
REQ-028 TxReady=1 iff the holding register is empty.
REQ-029 TxLoad with TxReady=1 SHALL fill the holding register; TxLoad with TxReady=0 SHALL be ignored.
REQ-030 TxLoad in the same cycle as a reload with the holding register empty SHALL bypass the holding register into the shift register, with no TxUnderrun pulse.
REQ-031 SPI_CS rising mid-byte SHALL return the FSM to IDLE, discard the partial Rx byte and Tx shift contents, keep the holding register, and not pulse RxValid.
REQ-032 Busy=1 in LOAD and SHIFT; Busy=0 in IDLE.

Reset
REQ-033 Reset SHALL force: FSM=IDLE, SPI_MISO=1, RxData=8'h00, RxValid=0, TxUnderrun=0, holding register empty (TxReady=1), Busy=0, bit counter=0, synchronisers=1.
REQ-034 Reset asserted mid-transfer SHALL abort immediately; the next byte SHALL start only on a fresh SPI_CS fall after reset release.

Structure
REQ-035 State encodings and the IDLE_BYTE default SHALL live in the shared package sd_spi_pkg.
REQ-036 The synchroniser SHALL be a separate sub-module, spi_sync (parameter SYNC_STAGES, reset value 1), instantiated three times.

Verification
REQ-037 Load 8'hA5, drive CS low, initiator sends 8'h3C: MISO bits 1,0,1,0,0,1,0,1; RxData=8'h3C; one RxValid pulse.
REQ-038 No TxLoad, CS low, 2 bytes: MISO all 1s; two TxUnderrun pulses; RxValid pulses twice.
REQ-039 Load 8'h40, then load 8'h95 during byte 1, with CS held low: MISO shows 8'h40 then 8'h95; TxReady drops and rises correctly.
REQ-040 CS rises after 5 bits: no RxValid; FSM returns to IDLE; next full byte is received correctly.
REQ-041 Reset pulsed after 3 bits: all outputs match their reset values; no RxValid.
REQ-042 TxLoad of 8'hFE in the same cycle as CS fall with the holding register empty: MISO sends 8'hFE; no TxUnderrun pulse.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared definitions for the SPI responder.
//   sd_spi_state_e            - responder FSM state encoding
//   SD_SPI_IDLE_BYTE_DEFAULT  - byte shifted out when nothing is queued
package sd_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } sd_spi_state_e;

  localparam logic [7:0] SD_SPI_IDLE_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-stage flip-flop synchroniser for one asynchronous bit.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, forces every stage to 1
//   d    - asynchronous input
//   q    - synchronised output (SYNC_STAGES clk cycles of latency)
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI mode-3 target (responder) clocked entirely by CLK.
// The SPI pins are oversampled through synchronisers; SPI_CLK edges are
// found by comparing the synchronised value with its one-cycle-old copy.
// Ports:
//   CLK, Reset          - system clock, asynchronous active-high reset
//   SPI_CLK/MOSI/CS     - initiator pins (CS active low, SPI_CLK idles high)
//   SPI_MISO            - serial data back to the initiator, MSB first
//   TxData/TxLoad/TxReady - transmit holding register handshake
//   RxData/RxValid      - last received byte, one-CLK pulse on update
//   TxUnderrun          - one-CLK pulse: a byte started with nothing queued
//   Busy                - a transfer is in progress
//   dbg_state           - current FSM state (sd_spi_state_e encoding)
//
// Transmit handshake: TxLoad is a valid and TxReady is a ready. A byte is
// transferred on a rising CLK edge where TxLoad and TxReady are both 1;
// TxLoad while TxReady is 0 has no effect. TxReady is 1 exactly when the
// holding register is empty.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = SD_SPI_IDLE_BYTE_DEFAULT
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       SPI_CLK,
  input  logic       SPI_MOSI,
  input  logic       SPI_CS,
  output logic       SPI_MISO,
  input  logic [7:0] TxData,
  input  logic       TxLoad,
  output logic       TxReady,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       TxUnderrun,
  output logic       Busy,
  output logic [1:0] dbg_state
);

  localparam int         SETTLE_CYCLES = SYNC_STAGES + 1;
  localparam logic [7:0] SETTLE_LAST   = 8'(SETTLE_CYCLES);

  // Synchronised pins and edge detection
  logic sclk_s, mosi_s, cs_s;
  logic sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_fall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(CLK), .rst(Reset), .d(SPI_CLK), .q(sclk_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(CLK), .rst(Reset), .d(SPI_MOSI), .q(mosi_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(CLK), .rst(Reset), .d(SPI_CS), .q(cs_s)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sclk_d <= 1'b1;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;

  // The synchronisers come out of reset holding 1 regardless of the pin, so
  // a CS that was already low during reset would look like a fresh fall once
  // the pipeline flushes. CS falls are only honoured after the pipeline has
  // flushed and CS has been seen high.
  logic [7:0] settle_q;
  logic       settled;
  logic       cs_armed_q;

  assign settled = (settle_q == SETTLE_LAST);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      settle_q   <= 8'd0;
      cs_armed_q <= 1'b0;
    end else begin
      if (!settled) settle_q <= settle_q + 8'd1;
      if (settled && cs_s) cs_armed_q <= 1'b1;
    end
  end

  // FSM
  sd_spi_state_e state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic          wrapped_q;     // 8 bits done; next SPI_CLK fall starts a new byte
  logic          do_clear, do_reload, do_shift, do_next_bit;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    do_clear    = 1'b0;
    do_reload   = 1'b0;
    do_shift    = 1'b0;
    do_next_bit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        do_clear = 1'b1;
        if (cs_fall && cs_armed_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        do_reload = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cs_s) begin
          // CS released: abandon whatever byte is in flight
          do_clear = 1'b1;
          state_d  = ST_IDLE;
        end else if (sclk_rise) begin
          do_shift = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt_q != 3'd0) do_next_bit = 1'b1;
          // With the counter at 0 the very first fall of a transfer only
          // confirms the bit 7 already placed by LOAD; a fall after a
          // completed byte starts the next one.
          else if (wrapped_q)    do_reload   = 1'b1;
        end
      end
      default: begin
        do_clear = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Choose the byte for a reload: holding register first, then a TxLoad
  // arriving in the same cycle (bypass), otherwise the idle filler.
  logic [7:0] reload_byte;
  logic       reload_from_hold, reload_bypass;

  logic [7:0] shreg_q;
  logic [7:0] hold_q;
  logic       hold_full_q;

  always_comb begin
    reload_byte      = IDLE_BYTE;
    reload_from_hold = 1'b0;
    reload_bypass    = 1'b0;
    if (hold_full_q) begin
      reload_byte      = hold_q;
      reload_from_hold = 1'b1;
    end else if (TxLoad) begin
      reload_byte   = TxData;
      reload_bypass = 1'b1;
    end
  end

  // Datapath
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      SPI_MISO    <= 1'b1;
      bit_cnt_q   <= 3'd0;
      wrapped_q   <= 1'b0;
      shreg_q     <= 8'h00;
      RxData      <= 8'h00;
      RxValid     <= 1'b0;
      TxUnderrun  <= 1'b0;
    end else begin
      RxValid    <= 1'b0;
      TxUnderrun <= 1'b0;
      if (do_clear) begin
        SPI_MISO  <= 1'b1;
        bit_cnt_q <= 3'd0;
        wrapped_q <= 1'b0;
      end
      if (do_reload) begin
        shreg_q   <= reload_byte;
        SPI_MISO  <= reload_byte[7];
        wrapped_q <= 1'b0;
        if (!reload_from_hold && !reload_bypass) TxUnderrun <= 1'b1;
      end
      if (do_shift) begin
        // One register serves both directions: the bit leaving the top has
        // already been driven, the synchronised MOSI enters the bottom.
        shreg_q   <= {shreg_q[6:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          RxData    <= {shreg_q[6:0], mosi_s};
          RxValid   <= 1'b1;
          wrapped_q <= 1'b1;
        end
      end
      if (do_next_bit) SPI_MISO <= shreg_q[7];
    end
  end

  // Transmit holding register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else if (do_reload && reload_from_hold) begin
      hold_full_q <= 1'b0;
    end else if (TxLoad && !hold_full_q && !(do_reload && reload_bypass)) begin
      hold_q      <= TxData;
      hold_full_q <= 1'b1;
    end
  end

  assign TxReady   = ~hold_full_q;
  assign Busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
module tb_sd_spi_responder;

  localparam int HALF = 8;  // CLK cycles per SPI_CLK phase

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       SPI_CLK = 1'b1, SPI_MOSI = 1'b1, SPI_CS = 1'b1;
  logic       SPI_MISO;
  logic [7:0] TxData = 8'h00;
  logic       TxLoad = 1'b0;
  logic       TxReady;
  logic [7:0] RxData;
  logic       RxValid, TxUnderrun, Busy;
  logic [1:0] dbg_state;

  always #5 CLK = ~CLK;

  sd_spi_responder dut (
    .CLK(CLK), .Reset(Reset),
    .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS),
    .SPI_MISO(SPI_MISO),
    .TxData(TxData), .TxLoad(TxLoad), .TxReady(TxReady),
    .RxData(RxData), .RxValid(RxValid), .TxUnderrun(TxUnderrun),
    .Busy(Busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];     // bytes the initiator sends, expected on RxData
  int rx_pulses = 0;
  int underruns = 0;
  logic prev_rxv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare: every RxValid must deliver the next expected byte
  always @(negedge CLK) begin
    if (Reset) begin
      prev_rxv <= 1'b0;
    end else begin
      if (RxValid) begin
        rx_pulses++;
        check("rx_single_pulse", {31'd0, prev_rxv}, 32'd0);
        if (exp_q.size() == 0) begin
          check("rx_unexpected", {24'd0, RxData}, 32'hDEAD);
        end else begin
          check("rx_data", {24'd0, RxData}, {24'd0, exp_q.pop_front()});
        end
      end
      if (TxUnderrun) underruns++;
      prev_rxv <= RxValid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic tx_load(input logic [7:0] b);
    @(negedge CLK);
    TxData = b;
    TxLoad = 1'b1;
    @(negedge CLK);
    TxLoad = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge CLK);
    SPI_CS = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    @(negedge CLK);
    SPI_CS = 1'b1;
    wait_clk(HALF);
  endtask

  // Mode 3 initiator: drive MOSI on the fall, sample MISO just before the rise
  task automatic spi_bits(input logic [7:0] mosi_byte, input int nbits, output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLK);
      SPI_CLK  = 1'b0;
      SPI_MOSI = mosi_byte[7-i];
      wait_clk(HALF);
      miso_byte[7-i] = SPI_MISO;
      SPI_CLK = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"},    {31'd0, SPI_MISO},   32'd1);
    check({tag, "_rxdata"},  {24'd0, RxData},     32'h00);
    check({tag, "_rxvalid"}, {31'd0, RxValid},    32'd0);
    check({tag, "_underrun"},{31'd0, TxUnderrun}, 32'd0);
    check({tag, "_txready"}, {31'd0, TxReady},    32'd1);
    check({tag, "_busy"},    {31'd0, Busy},       32'd0);
    check({tag, "_state"},   {30'd0, dbg_state},  32'd0);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] r;
  int rx_base, ur_base;
  bit seen;

  initial begin
    wait_clk(4);
    check_reset_values("reset");
    @(negedge CLK);
    Reset = 1'b0;
    wait_clk(6);

    // Queued 8'hA5, initiator sends 8'h3C
    rx_base = rx_pulses; ur_base = underruns;
    tx_load(8'hA5);
    check("t1_txready_full", {31'd0, TxReady}, 32'd0);
    cs_low();
    check("t1_busy", {31'd0, Busy}, 32'd1);
    check("t1_txready_consumed", {31'd0, TxReady}, 32'd1);
    exp_q.push_back(8'h3C);
    spi_bits(8'h3C, 8, r);
    check("t1_miso_byte", {24'd0, r}, 32'hA5);
    cs_high();
    check("t1_rxdata_lit", {24'd0, RxData}, 32'h3C);
    check("t1_rx_pulses", rx_pulses - rx_base, 1);
    check("t1_underruns", underruns - ur_base, 0);
    check("t1_idle_miso", {31'd0, SPI_MISO}, 32'd1);

    // Nothing queued, two back-to-back bytes
    rx_base = rx_pulses; ur_base = underruns;
    cs_low();
    exp_q.push_back(8'h12);
    spi_bits(8'h12, 8, r);
    check("t2_miso_b0", {24'd0, r}, 32'hFF);
    exp_q.push_back(8'h34);
    spi_bits(8'h34, 8, r);
    check("t2_miso_b1", {24'd0, r}, 32'hFF);
    cs_high();
    check("t2_underruns", underruns - ur_base, 2);
    check("t2_rx_pulses", rx_pulses - rx_base, 2);
    check("t2_rxdata_lit", {24'd0, RxData}, 32'h34);

    // 8'h40 then 8'h95 queued during the first byte
    rx_base = rx_pulses; ur_base = underruns;
    tx_load(8'h40);
    cs_low();
    check("t3_txready_after_load", {31'd0, TxReady}, 32'd1);
    tx_load(8'h95);
    check("t3_txready_held", {31'd0, TxReady}, 32'd0);
    exp_q.push_back(8'hC1);
    spi_bits(8'hC1, 8, r);
    check("t3_miso_b0", {24'd0, r}, 32'h40);
    check("t3_txready_before_b1", {31'd0, TxReady}, 32'd0);
    exp_q.push_back(8'h0F);
    spi_bits(8'h0F, 8, r);
    check("t3_miso_b1", {24'd0, r}, 32'h95);
    check("t3_txready_end", {31'd0, TxReady}, 32'd1);
    cs_high();
    check("t3_underruns", underruns - ur_base, 0);
    check("t3_rx_pulses", rx_pulses - rx_base, 2);

    // CS released after 5 bits, then a full byte
    rx_base = rx_pulses;
    cs_low();
    spi_bits(8'hAB, 5, r);
    cs_high();
    check("t4_no_rx", rx_pulses - rx_base, 0);
    check("t4_state_idle", {30'd0, dbg_state}, 32'd0);
    check("t4_busy", {31'd0, Busy}, 32'd0);
    cs_low();
    exp_q.push_back(8'h5A);
    spi_bits(8'h5A, 8, r);
    check("t4_miso", {24'd0, r}, 32'hFF);
    cs_high();
    check("t4_rx_pulses", rx_pulses - rx_base, 1);
    check("t4_rxdata_lit", {24'd0, RxData}, 32'h5A);

    // Reset after 3 bits with a byte sitting in the holding register
    rx_base = rx_pulses;
    cs_low();
    tx_load(8'h11);
    check("t5_txready_held", {31'd0, TxReady}, 32'd0);
    spi_bits(8'h77, 3, r);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    check_reset_values("t5");
    @(negedge CLK);
    Reset = 1'b0;
    wait_clk(20);  // CS still low: no fresh fall, must stay idle
    check("t5_still_idle", {30'd0, dbg_state}, 32'd0);
    check("t5_no_busy", {31'd0, Busy}, 32'd0);
    check("t5_no_rx", rx_pulses - rx_base, 0);
    cs_high();
    cs_low();
    exp_q.push_back(8'hC3);
    spi_bits(8'hC3, 8, r);
    check("t5_miso_after", {24'd0, r}, 32'hFF);
    cs_high();
    check("t5_rx_pulses", rx_pulses - rx_base, 1);

    // TxLoad lands in the reload cycle with the holding register empty
    ur_base = underruns;
    @(negedge CLK);
    SPI_CS = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (dbg_state == 2'd1) begin
        TxData = 8'hFE;
        TxLoad = 1'b1;
        seen   = 1'b1;
      end
    end
    check("t6_load_state_seen", {31'd0, seen}, 32'd1);
    @(negedge CLK);
    TxLoad = 1'b0;
    check("t6_hold_bypassed", {31'd0, TxReady}, 32'd1);
    wait_clk(HALF);
    exp_q.push_back(8'h81);
    spi_bits(8'h81, 8, r);
    check("t6_miso", {24'd0, r}, 32'hFE);
    cs_high();
    check("t6_underruns", underruns - ur_base, 0);

    check("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
